wr_sel_decoder: RTL and testbench
=================================

# wr_sel_decoder

Parametrised, registered N-to-2^N one-hot decoder with a valid/ready handshake on both sides. It is the successor to the fixed 2-to-4 combinational decoder. It drives the register-file write-enable lines in the single-cycle MIPS datapath and any other one-hot select bus in the design. It can optionally mask address 0, which keeps MIPS `$zero` unwritable. It also provides optional saturating event counters for debug.

## Interface
- `ADDR_W`, default 5: decoder input width; legal range 1..6; output width is `2**ADDR_W`.
- `MASK_ZERO`, default 1: when 1, an enabled decode of address 0 yields an all-zero one-hot and raises `out_masked`.
- `COUNT_W`, default 16: width of each statistics counter (used only with `WR_SEL_STATS_EN`).
- `clk`, input, 1: single clock; all state updates on rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: upstream request valid.
- `in_ready`, output, 1: block can accept a request this cycle.
- `in_addr`, input, `ADDR_W`: address to decode.
- `in_en`, input, 1: write enable; 0 means the transfer completes with an all-zero one-hot.
- `out_valid`, output, 1: output register holds a result.
- `out_ready`, input, 1: downstream accepts result.
- `out_onehot`, output, `2**ADDR_W`: decoded one-hot (or all-zero).
- `out_addr`, output, `ADDR_W`: registered copy of the accepted `in_addr`.
- `out_masked`, output, 1: result was suppressed by `MASK_ZERO`.
- `stat_dec`, output, `COUNT_W`: number of non-zero one-hots delivered (present only with the macro).
- `stat_mask`, output, `COUNT_W`: number of masked results delivered (present only with the macro).

## Operation
- Single output register stage, no internal FIFO.
- `in_ready` is the combinational term `!reset && (!out_valid || out_ready)`.
- Accept happens when `in_valid && in_ready`. On the next edge, `out_valid` becomes 1 and the output register loads these values:
  - `out_onehot = in_en ? (1 << in_addr) : 0`, with bit 0 cleared when `MASK_ZERO && in_addr == 0`.
  - `out_addr = in_addr`.
  - `out_masked = MASK_ZERO && in_en && in_addr == 0`.
- Drain happens when `out_valid && out_ready`. Without a simultaneous accept, `out_valid` becomes 0 on the next edge. The data registers keep their values but are don't-care.
- Simultaneous drain and accept: the new result replaces the old in the same edge and `out_valid` stays 1. This gives a throughput of one transfer per cycle.
- Stall (`out_valid && !out_ready`): all outputs hold bit-stable and `in_ready` is 0.
- `out_onehot` always has a population count of 0 or 1.
- In-range addressing is guaranteed because `in_addr` spans exactly `2**ADDR_W` codes.

## Timing
- Latency: 1 cycle from accept edge to `out_valid`.
- Reset values:
  - `out_valid=0`, `out_onehot=0`, `out_addr=0`, `out_masked=0`.
  - `stat_dec=0`, `stat_mask=0`.
  - `in_ready=0` while `reset` is high and 1 on the first cycle after release.
- Reset asserted mid-transfer: any pending result is discarded immediately (asynchronously). Nothing is delivered after release.
- Counters update on the drain edge, not the accept edge.
- Counters saturate at all-ones and never wrap.
- Inputs are sampled only on accept. Changing `in_addr` or `in_en` while `in_ready=0` has no effect.

## Configuration
- `WR_SEL_STATS_EN` defined: `stat_dec` and `stat_mask` ports and their counters are present.
  - `stat_dec` increments by 1 on each drain with a non-zero one-hot.
  - `stat_mask` increments by 1 on each drain with `out_masked=1`.
- `WR_SEL_STATS_EN` undefined: both ports and their counters are absent. Handshake and decode behaviour are identical to the defined case.

## Test plan
- `ADDR_W=2`, `MASK_ZERO=0`, `out_ready=1`, `in_en=1`, `in_addr` = 0,1,2,3 back-to-back -> `out_onehot` = 1,2,4,8 on consecutive cycles, each one cycle after accept; `out_valid` continuously 1.
- `ADDR_W=5`, `MASK_ZERO=1`: `in_addr=0`, `in_en=1` -> `out_onehot=0`, `out_masked=1`. Then `in_addr=31` -> `out_onehot=32'h8000_0000`, `out_masked=0`.
- `in_en=0`, `in_addr=7` -> `out_valid=1`, `out_onehot=0`, `out_addr=7`, `out_masked=0`.
- Accept `in_addr=3`, then hold `out_ready=0` for 3 cycles while `in_valid=1` with `in_addr=9` -> `out_onehot=8` held stable and `in_ready=0` for all 3 cycles. When `out_ready=1`, `in_addr=9` is accepted on the drain edge and `out_onehot=0x200` appears the next cycle.
- Assert `reset` asynchronously while `out_valid=1` -> all outputs go to 0 without a clock edge and `in_ready=0`. After release: `in_ready=1` and no stale result is delivered.
- `WR_SEL_STATS_EN`, `COUNT_W=3`: 9 enabled non-zero drains and 2 masked drains -> `stat_dec=7` (saturated), `stat_mask=2`.

Source files
------------

// File: rtl/wr_sel_decoder.sv
// wr_sel_decoder: registered N-to-2^N one-hot decoder with valid/ready on both sides.
// Define WR_SEL_STATS_EN to add the saturating stat_dec/stat_mask delivery counters.
module wr_sel_decoder #(
  parameter int ADDR_W    = 5,
  parameter bit MASK_ZERO = 1'b1,
  parameter int COUNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic                    in_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(2**ADDR_W)-1:0]  out_onehot,
  output logic [ADDR_W-1:0]       out_addr,
  output logic                    out_masked
`ifdef WR_SEL_STATS_EN
  ,
  output logic [COUNT_W-1:0]      stat_dec,
  output logic [COUNT_W-1:0]      stat_mask
`endif
);

  localparam int OUT_W = 2**ADDR_W;

  // Address 0 is suppressed when masking is on, so $zero never sees a write strobe.
  function automatic logic decode_masked(input logic [ADDR_W-1:0] addr, input logic en);
    return MASK_ZERO && en && (addr == {ADDR_W{1'b0}});
  endfunction

  function automatic logic [OUT_W-1:0] decode_onehot(input logic [ADDR_W-1:0] addr, input logic en);
    logic [OUT_W-1:0] onehot;
    if (!en) begin
      onehot = {OUT_W{1'b0}};
    end else if (decode_masked(addr, en)) begin
      onehot = {OUT_W{1'b0}};
    end else begin
      onehot = OUT_W'(1'b1) << addr;
    end
    return onehot;
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] cnt, input logic hit);
    logic [COUNT_W-1:0] res;
    if (hit && (cnt != {COUNT_W{1'b1}})) begin
      res = cnt + COUNT_W'(1'b1);
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  logic              out_valid_r;
  logic [OUT_W-1:0]  out_onehot_r;
  logic [ADDR_W-1:0] out_addr_r;
  logic              out_masked_r;

  logic              in_ready_s;
  logic              accept_s;
  logic              drain_s;
  logic              valid_nxt_s;
  logic [OUT_W-1:0]  onehot_nxt_s;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic              masked_nxt_s;

  // Upstream ready: free slot, or the held result leaves this cycle.
  always_comb begin
    in_ready_s = 1'b0;
    if (reset) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = !out_valid_r || out_ready;
    end
  end

  assign accept_s = in_valid && in_ready_s;
  assign drain_s  = out_valid_r && out_ready;

  // Next state of the single output stage; accept wins over drain so throughput is one per cycle.
  always_comb begin
    valid_nxt_s  = out_valid_r;
    onehot_nxt_s = out_onehot_r;
    addr_nxt_s   = out_addr_r;
    masked_nxt_s = out_masked_r;
    if (accept_s) begin
      valid_nxt_s  = 1'b1;
      onehot_nxt_s = decode_onehot(in_addr, in_en);
      addr_nxt_s   = in_addr;
      masked_nxt_s = decode_masked(in_addr, in_en);
    end else if (drain_s) begin
      valid_nxt_s  = 1'b0;
    end else begin
      valid_nxt_s  = out_valid_r;
    end
  end

  // Output register; reset discards any pending result immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r  <= 1'b0;
      out_onehot_r <= {OUT_W{1'b0}};
      out_addr_r   <= {ADDR_W{1'b0}};
      out_masked_r <= 1'b0;
    end else begin
      out_valid_r  <= valid_nxt_s;
      out_onehot_r <= onehot_nxt_s;
      out_addr_r   <= addr_nxt_s;
      out_masked_r <= masked_nxt_s;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_onehot = out_onehot_r;
  assign out_addr   = out_addr_r;
  assign out_masked = out_masked_r;

`ifdef WR_SEL_STATS_EN
  logic [COUNT_W-1:0] stat_dec_r;
  logic [COUNT_W-1:0] stat_mask_r;

  // Delivery counters advance on the drain edge and stick at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_dec_r  <= {COUNT_W{1'b0}};
      stat_mask_r <= {COUNT_W{1'b0}};
    end else begin
      stat_dec_r  <= sat_inc(stat_dec_r, drain_s && (|out_onehot_r));
      stat_mask_r <= sat_inc(stat_mask_r, drain_s && out_masked_r);
    end
  end

  assign stat_dec  = stat_dec_r;
  assign stat_mask = stat_mask_r;
`endif

endmodule

// File: tb/tb_wr_sel_decoder.sv
// Bench for wr_sel_decoder: two configurations (2-bit unmasked, 5-bit masked) against a
// behavioural model of accept/drain/stall plus directed cases for the listed scenarios.
module tb_wr_sel_decoder;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int aw [2] = '{2, 5};
  bit mz [2] = '{1'b0, 1'b1};
  int cw [2] = '{16, 3};

  bit         i_valid [2];
  bit         i_en    [2];
  bit         i_ordy  [2];
  logic [5:0] i_addr  [2];

  logic        a_in_ready, a_out_valid, a_out_masked;
  logic [1:0]  a_out_addr;
  logic [3:0]  a_out_onehot;
  logic        b_in_ready, b_out_valid, b_out_masked;
  logic [4:0]  b_out_addr;
  logic [31:0] b_out_onehot;
`ifdef WR_SEL_STATS_EN
  logic [15:0] a_stat_dec, a_stat_mask;
  logic [2:0]  b_stat_dec, b_stat_mask;
`endif

  wr_sel_decoder #(.ADDR_W(2), .MASK_ZERO(1'b0), .COUNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset),
    .in_valid(i_valid[0]), .in_ready(a_in_ready), .in_addr(i_addr[0][1:0]), .in_en(i_en[0]),
    .out_valid(a_out_valid), .out_ready(i_ordy[0]), .out_onehot(a_out_onehot),
    .out_addr(a_out_addr), .out_masked(a_out_masked)
`ifdef WR_SEL_STATS_EN
    , .stat_dec(a_stat_dec), .stat_mask(a_stat_mask)
`endif
  );

  wr_sel_decoder #(.ADDR_W(5), .MASK_ZERO(1'b1), .COUNT_W(3)) u_dut_b (
    .clk(clk), .reset(reset),
    .in_valid(i_valid[1]), .in_ready(b_in_ready), .in_addr(i_addr[1][4:0]), .in_en(i_en[1]),
    .out_valid(b_out_valid), .out_ready(i_ordy[1]), .out_onehot(b_out_onehot),
    .out_addr(b_out_addr), .out_masked(b_out_masked)
`ifdef WR_SEL_STATS_EN
    , .stat_dec(b_stat_dec), .stat_mask(b_stat_mask)
`endif
  );

  // reference model state
  bit          m_valid  [2];
  logic [63:0] m_onehot [2];
  logic [5:0]  m_addr   [2];
  bit          m_masked [2];
  longint      m_dec    [2];
  longint      m_mask   [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0; m_onehot[k] = 64'd0; m_addr[k] = 6'd0;
      m_masked[k] = 1'b0; m_dec[k] = 0; m_mask[k] = 0;
    end
  endtask

  task automatic set_in(input int k, input bit v, input logic [5:0] a, input bit en, input bit rdy);
    i_valid[k] = v; i_addr[k] = a; i_en[k] = en; i_ordy[k] = rdy;
  endtask

  task automatic check_outputs(input string ph);
    for (int k = 0; k < 2; k++) begin
      logic [63:0] g_rdy, g_v, g_oh, g_a, g_m, g_d, g_s;
      g_d = 64'd0; g_s = 64'd0;
      if (k == 0) begin
        g_rdy = 64'(a_in_ready); g_v = 64'(a_out_valid); g_oh = 64'(a_out_onehot);
        g_a = 64'(a_out_addr); g_m = 64'(a_out_masked);
`ifdef WR_SEL_STATS_EN
        g_d = 64'(a_stat_dec); g_s = 64'(a_stat_mask);
`endif
      end else begin
        g_rdy = 64'(b_in_ready); g_v = 64'(b_out_valid); g_oh = 64'(b_out_onehot);
        g_a = 64'(b_out_addr); g_m = 64'(b_out_masked);
`ifdef WR_SEL_STATS_EN
        g_d = 64'(b_stat_dec); g_s = 64'(b_stat_mask);
`endif
      end
      chk($sformatf("%s[%0d].in_ready", ph, k), g_rdy, 64'(!reset && (!m_valid[k] || i_ordy[k])));
      chk($sformatf("%s[%0d].out_valid", ph, k), g_v, 64'(m_valid[k]));
      if (m_valid[k] || reset) begin
        chk($sformatf("%s[%0d].out_onehot", ph, k), g_oh, m_onehot[k]);
        chk($sformatf("%s[%0d].out_addr", ph, k), g_a, 64'(m_addr[k]));
        chk($sformatf("%s[%0d].out_masked", ph, k), g_m, 64'(m_masked[k]));
      end
`ifdef WR_SEL_STATS_EN
      chk($sformatf("%s[%0d].stat_dec", ph, k), g_d, 64'(m_dec[k]));
      chk($sformatf("%s[%0d].stat_mask", ph, k), g_s, 64'(m_mask[k]));
`endif
    end
  endtask

  // Called at a falling edge with inputs already set: check, predict, cross one rising edge.
  task automatic step(input string ph);
    bit          nv [2];
    logic [63:0] noh[2];
    logic [5:0]  na [2];
    bit          nm [2];
    longint      nd [2];
    longint      ns [2];
    #1;
    check_outputs(ph);
    for (int k = 0; k < 2; k++) begin
      longint cap;
      cap = (longint'(1) << cw[k]) - 1;
      nv[k] = m_valid[k]; noh[k] = m_onehot[k]; na[k] = m_addr[k];
      nm[k] = m_masked[k]; nd[k] = m_dec[k]; ns[k] = m_mask[k];
      if (reset) begin
        nv[k] = 1'b0; noh[k] = 64'd0; na[k] = 6'd0; nm[k] = 1'b0; nd[k] = 0; ns[k] = 0;
      end else begin
        bit room;
        room = !m_valid[k] || i_ordy[k];
        if (m_valid[k] && i_ordy[k]) begin
          if (m_onehot[k] != 64'd0 && nd[k] < cap) nd[k] = nd[k] + 1;
          if (m_masked[k] && ns[k] < cap) ns[k] = ns[k] + 1;
          nv[k] = 1'b0;
        end
        if (i_valid[k] && room) begin
          nv[k] = 1'b1;
          na[k] = i_addr[k];
          nm[k] = mz[k] && i_en[k] && (i_addr[k] == 6'd0);
          noh[k] = (i_en[k] && !nm[k]) ? (64'd1 << i_addr[k]) : 64'd0;
        end
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = nv[k]; m_onehot[k] = noh[k]; m_addr[k] = na[k];
      m_masked[k] = nm[k]; m_dec[k] = nd[k]; m_mask[k] = ns[k];
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    for (int k = 0; k < 2; k++) set_in(k, 1'b0, 6'd0, 1'b0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    step("reset");
    step("reset");
    reset = 1'b0;
    step("release");

    // A: back-to-back 0..3 at full throughput
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1'b1, 6'(i), 1'b1, 1'b1);
      step("a_seq");
      chk("a_seq_onehot", 64'(a_out_onehot), 64'd1 << i);
      chk("a_seq_valid", 64'(a_out_valid), 64'd1);
    end
    set_in(0, 1'b0, 6'd0, 1'b0, 1'b1);

    // B: masked zero, top address, disabled write
    set_in(1, 1'b1, 6'd0, 1'b1, 1'b1);
    step("b_zero");
    chk("b_zero_onehot", 64'(b_out_onehot), 64'd0);
    chk("b_zero_masked", 64'(b_out_masked), 64'd1);
    set_in(1, 1'b1, 6'd31, 1'b1, 1'b1);
    step("b_top");
    chk("b_top_onehot", 64'(b_out_onehot), 64'h8000_0000);
    chk("b_top_masked", 64'(b_out_masked), 64'd0);
    set_in(1, 1'b1, 6'd7, 1'b0, 1'b1);
    step("b_en0");
    chk("b_en0_valid", 64'(b_out_valid), 64'd1);
    chk("b_en0_onehot", 64'(b_out_onehot), 64'd0);
    chk("b_en0_addr", 64'(b_out_addr), 64'd7);

    // B: stall with a waiting request, then accept on the drain edge
    set_in(1, 1'b1, 6'd3, 1'b1, 1'b1);
    step("b_pre_stall");
    set_in(1, 1'b1, 6'd9, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("b_stall_in_ready", 64'(b_in_ready), 64'd0);
      chk("b_stall_onehot", 64'(b_out_onehot), 64'd8);
      step("b_stall");
    end
    set_in(1, 1'b1, 6'd9, 1'b1, 1'b1);
    step("b_unstall");
    chk("b_unstall_onehot", 64'(b_out_onehot), 64'h200);
    set_in(1, 1'b0, 6'd0, 1'b0, 1'b1);
    step("b_drain");

    // asynchronous reset with results held in both instances
    set_in(0, 1'b1, 6'd2, 1'b1, 1'b0);
    set_in(1, 1'b1, 6'd5, 1'b1, 1'b0);
    step("pre_areset");
    #2;
    reset = 1'b1;
    #1;
    chk("areset_a_valid", 64'(a_out_valid), 64'd0);
    chk("areset_a_onehot", 64'(a_out_onehot), 64'd0);
    chk("areset_b_valid", 64'(b_out_valid), 64'd0);
    chk("areset_b_onehot", 64'(b_out_onehot), 64'd0);
    chk("areset_b_in_ready", 64'(b_in_ready), 64'd0);
    model_reset();
    set_in(0, 1'b1, 6'd1, 1'b1, 1'b1);
    set_in(1, 1'b1, 6'd4, 1'b1, 1'b1);
    @(negedge clk);
    step("areset_hold");
    reset = 1'b0;
    set_in(0, 1'b0, 6'd0, 1'b0, 1'b1);
    set_in(1, 1'b0, 6'd0, 1'b0, 1'b1);
    step("areset_release");
    step("areset_idle");
    chk("areset_no_stale_a", 64'(a_out_valid), 64'd0);
    chk("areset_no_stale_b", 64'(b_out_valid), 64'd0);

    // B: nine non-zero and two masked deliveries into a 3-bit counter
    for (int i = 1; i <= 9; i++) begin
      set_in(1, 1'b1, 6'(i), 1'b1, 1'b1);
      step("b_stat_dec");
    end
    for (int i = 0; i < 2; i++) begin
      set_in(1, 1'b1, 6'd0, 1'b1, 1'b1);
      step("b_stat_mask");
    end
    set_in(1, 1'b0, 6'd0, 1'b0, 1'b1);
    step("b_stat_drain");
`ifdef WR_SEL_STATS_EN
    chk("b_stat_dec_sat", 64'(b_stat_dec), 64'd7);
    chk("b_stat_mask_cnt", 64'(b_stat_mask), 64'd2);
`endif

    // randomized traffic with random backpressure
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 2; k++) begin
        logic [5:0] a;
        a = 6'($urandom_range(0, (1 << aw[k]) - 1));
        if ($urandom_range(0, 5) == 0) a = 6'd0;
        set_in(k, $urandom_range(0, 3) != 0, a, $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0);
      end
      step("rand");
    end
    for (int k = 0; k < 2; k++) set_in(k, 1'b0, 6'd0, 1'b0, 1'b1);
    step("final");
    step("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
